// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
//   Synchronous circular FIFO decoupling a producer (e.g. UART RX) from a
//   consumer (e.g. the bootloader loader FSM). Depth and width are
//   independent. Status outputs include programmable almost-full/almost-empty
//   thresholds, occupancy/free counts and sticky error flags.
//
// Parameters
//   DEPTH    number of entries (power of two, >= 2)
//   WIDTH    data width in bits
//   AF_LEVEL almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous clear of contents, highest priority
//   wr_en        in   push request
//   wr_data      in   push data
//   rd_en        in   pop request
//   rd_data      out  head entry (first-word-fall-through)
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  occupied entries, 0..DEPTH
//   free         out  DEPTH - count
//   overflow     out  sticky: a push was rejected
//   underflow    out  sticky: a pop was rejected
//   err_clr      in   synchronous clear of overflow/underflow
module sync_fifo_prog #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    free,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int AW = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;
    logic             ovf_set;
    logic             unf_set;

    // Pointers carry one extra wrap bit, so the plain difference is the
    // occupancy even after either pointer has wrapped.
    assign count        = wr_ptr - rd_ptr;
    assign free         = DEPTH_C - count;
    assign full         = (count == DEPTH_C);
    assign empty        = (wr_ptr == rd_ptr);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign rd_data      = mem[rd_ptr[AW-1:0]];

    // Acceptance: a pop is taken whenever the FIFO holds data. A push is
    // taken when there is room, or when full but a pop frees the head slot
    // in the same cycle. A pop on an empty FIFO is never satisfied by the
    // data being pushed that cycle. flush overrides both requests.
    assign rd_ok   = rd_en & ~empty & ~flush;
    assign wr_ok   = wr_en & (~full | rd_en) & ~flush;
    assign ovf_set = wr_en & ~(~full | rd_en) & ~flush;
    assign unf_set = rd_en & empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (unf_set)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog
//   Self-checking bench for sync_fifo_prog (DEPTH=8, WIDTH=8, AF=6, AE=2).
//   A queue-based model tracks contents and sticky flags; after every clock
//   step all outputs are compared with values derived from that model.
module tb_sync_fifo_prog;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    free;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    int n_vec;
    int n_err;

    logic [WIDTH-1:0] mq[$];
    logic             m_ov;
    logic             m_un;

    sync_fifo_prog #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .free(free),
        .overflow(overflow),
        .underflow(underflow),
        .err_clr(err_clr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // compares every output with the model's view
    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(sz));
        chk({tag, ".free"}, 32'(free), 32'(DEPTH - sz));
        chk({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_un));
        if (sz > 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
    endtask

    // driver: apply one cycle of requests, advance the model, check after edge
    task automatic step(input string tag, input logic f, input logic we,
                        input logic [WIDTH-1:0] wd, input logic re, input logic ec);
        int  sz;
        bit  pop_ok;
        bit  push_ok;
        flush   = f;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        err_clr = ec;
        sz = mq.size();
        if (ec) begin
            m_ov = 1'b0;
            m_un = 1'b0;
        end
        if (f) begin
            mq.delete();
        end else begin
            pop_ok  = re && (sz > 0);
            push_ok = we && ((sz < DEPTH) || re);
            if (re && sz == 0) m_un = 1'b1;
            if (we && !push_ok) m_ov = 1'b1;
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(wd);
        end
        @(posedge clk);
        #1;
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic [WIDTH-1:0] d);
        step(tag, 1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        err_clr = 1'b0;

        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fill then drain
        for (int i = 0; i < DEPTH; i++) push("fill", 8'(8'h10 + i));
        for (int i = 0; i < DEPTH; i++) pop("drain");

        // alternating push/pop across pointer wrap
        for (int i = 0; i < 20; i++) begin
            push("wrap_push", 8'(8'h40 + i));
            pop("wrap_pop");
        end

        // simultaneous push/pop at full
        for (int i = 0; i < DEPTH; i++) push("refill", 8'(8'h10 + i));
        step("full_pushpop", 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);

        // rejected push, then err_clr coinciding with a new overflow
        push("ovf_push", 8'h99);
        step("ovf_clr_same", 1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        step("err_clr", 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // drain (contents must show 0xAA at the tail), pop on empty
        for (int i = 0; i < DEPTH; i++) pop("drain2");
        pop("unf_pop");
        step("err_clr2", 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // simultaneous push/pop at empty: pop rejected, data lands
        step("empty_pushpop", 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        pop("pop55");

        // flush with wr_en/rd_en at count 5, flags held
        for (int i = 0; i < 5; i++) push("pre_flush", 8'(8'h20 + i));
        step("flush", 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
        push("post_flush", 8'h33);
        pop("pop33");
        step("err_clr3", 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // asynchronous reset between edges at count 4
        for (int i = 0; i < 4; i++) push("pre_rst", 8'(8'h60 + i));
        pop("unused_pop");
        push("pre_rst2", 8'h64);
        #3;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push("post_rst", 8'h77);
        pop("pop77");

        // randomized phases with shifting push/pop bias
        for (int i = 0; i < 400; i++) begin
            logic f;
            logic we;
            logic re;
            logic ec;
            int   wp;
            wp = ((i / 50) % 2 == 0) ? 80 : 25;
            f  = ($urandom_range(0, 39) == 0);
            we = ($urandom_range(0, 99) < wp);
            re = ($urandom_range(0, 99) < (100 - wp));
            ec = ($urandom_range(0, 9) == 0);
            step("rand", f, we, 8'($urandom), re, ec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
